mpdiv_phase_sched: RTL

Edge scheduler for the fractional output divider. It converts a fractional frequency control word (FCW, in CLK periods) into a timed stream of output edges. For each edge it emits a 3-bit index and a one-hot select that drive the glitch-free mux on the 8 interleaved divider phases. It also emits a sub-CLK residue code for the downstream 64-step DTC. It runs on the same CLK and NARST as the multi-phase divider, so its phase position counter stays aligned with the divider counter.

---
 rtl/mpdiv_sched_pkg.sv | 11 +
 rtl/mpdiv_phase_sched_if.sv | 23 ++
 rtl/mpdiv_sched_acc.sv | 36 +++
 rtl/mpdiv_phase_sched.sv | 88 ++++++++
 4 files changed

// File: rtl/mpdiv_sched_pkg.sv
// mpdiv_sched_pkg: shared types and constants for the fractional edge scheduler.
// The LFSR constants are used only when MPDIV_SCHED_DITHER_EN is defined.
package mpdiv_sched_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
   localparam int DEF_INT_W = 8;
   localparam int DEF_FRAC_W = 16;
   localparam int DEF_DTC_W = 6;
   localparam int MIN_INT = 2;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/mpdiv_phase_sched_if.sv
// mpdiv_phase_sched_if: run/config inputs and edge/phase outputs of the edge scheduler.
interface mpdiv_phase_sched_if
   import mpdiv_sched_pkg::*;
#(
   parameter int INT_W = DEF_INT_W,
   parameter int FRAC_W = DEF_FRAC_W,
   parameter int DTC_W = DEF_DTC_W
);
   logic i_en;
   logic i_cfg_vld;
   logic o_cfg_rdy;
   logic [INT_W-1:0] i_cfg_int;
   logic [FRAC_W-1:0] i_cfg_frac;
   logic o_edge;
   logic [2:0] o_phidx;
   logic [7:0] o_phsel;
   logic [DTC_W-1:0] o_dtc_code;
   logic o_busy;
   modport master (output i_en, i_cfg_vld, i_cfg_int, i_cfg_frac,
                   input o_cfg_rdy, o_edge, o_phidx, o_phsel, o_dtc_code, o_busy);
   modport slave (input i_en, i_cfg_vld, i_cfg_int, i_cfg_frac,
                  output o_cfg_rdy, o_edge, o_phidx, o_phsel, o_dtc_code, o_busy);
endinterface

// File: rtl/mpdiv_sched_acc.sv
// mpdiv_sched_acc: fractional accumulator, carry and DTC residue code for the edge scheduler.
// MPDIV_SCHED_DITHER_EN adds an LFSR bit into the accumulator LSB on every step.
module mpdiv_sched_acc
   import mpdiv_sched_pkg::*;
#(
   parameter int FRAC_W = DEF_FRAC_W,
   parameter int DTC_W = DEF_DTC_W
) (
   input logic CLK,
   input logic NARST,
   input logic i_step,
   input logic i_clr,
   input logic [FRAC_W-1:0] i_frac,
   output logic o_carry,
   output logic [DTC_W-1:0] o_code
);
   logic [FRAC_W-1:0] r_acc;
   logic [FRAC_W:0] w_sum;
   logic w_dith;
`ifdef MPDIV_SCHED_DITHER_EN
   logic [15:0] r_lfsr;
   always_ff @(posedge CLK or negedge NARST)
      if (!NARST) r_lfsr <= LFSR_SEED;
      else if (i_step) r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
   assign w_dith = r_lfsr[0];
`else
   assign w_dith = 1'b0;
`endif
   assign w_sum = {1'b0, r_acc} + {1'b0, i_frac} + (FRAC_W+1)'(w_dith);
   always_ff @(posedge CLK or negedge NARST)
      if (!NARST) r_acc <= '0;
      else if (i_clr) r_acc <= '0;
      else if (i_step) r_acc <= w_sum[FRAC_W-1:0];
   assign o_carry = w_sum[FRAC_W];
   assign o_code = r_acc[FRAC_W-1 -: DTC_W];
endmodule

// File: rtl/mpdiv_phase_sched.sv
// mpdiv_phase_sched: turns a fractional FCW into timed edges with phase select and DTC residue.
// Build option MPDIV_SCHED_DITHER_EN enables LFSR dither inside mpdiv_sched_acc.
module mpdiv_phase_sched
   import mpdiv_sched_pkg::*;
#(
   parameter int INT_W = DEF_INT_W,
   parameter int FRAC_W = DEF_FRAC_W,
   parameter int DTC_W = DEF_DTC_W
) (
   input logic CLK,
   input logic NARST,
   mpdiv_phase_sched_if.slave bus
);
   state_t r_state, w_next;
   logic [2:0] r_pos;
   logic r_sh_vld;
   logic [INT_W-1:0] r_sh_int, r_act_int, r_wait, w_int_nx;
   logic [FRAC_W-1:0] r_sh_frac, r_act_frac;
   logic r_edge;
   logic [2:0] r_phidx;
   logic [7:0] r_phsel;
   logic [DTC_W-1:0] r_dtc, w_code;
   logic w_xfer, w_load, w_edge_cyc, w_busy, w_take, w_carry;
   assign w_xfer = bus.i_cfg_vld && !r_sh_vld;
   assign w_take = r_sh_vld && (w_load || w_edge_cyc);
   // a pending shadow word governs the wait computed in the same cycle it is taken
   assign w_int_nx = w_take ? r_sh_int : r_act_int;
   always_ff @(posedge CLK or negedge NARST)
      if (!NARST) r_state <= IDLE;
      else r_state <= w_next;
   always_comb
      w_next = (r_state == IDLE) ? ((bus.i_en && r_sh_vld) ? LOAD : IDLE) :
               (r_state == LOAD) ? RUN :
               (w_edge_cyc && !bus.i_en) ? IDLE : RUN;
   always_comb begin
      w_load = (r_state == LOAD);
      w_edge_cyc = (r_state == RUN) && (r_wait == '0);
      w_busy = (r_state != IDLE);
   end
   always_ff @(posedge CLK or negedge NARST)
      if (!NARST) begin
         r_pos <= '0;
         r_sh_vld <= 1'b0;
         r_sh_int <= '0;
         r_sh_frac <= '0;
         r_act_int <= '0;
         r_act_frac <= '0;
         r_wait <= '0;
         r_edge <= 1'b0;
         r_phidx <= '0;
         r_phsel <= '0;
         r_dtc <= '0;
      end else begin
         r_pos <= r_pos + 3'd1;
         r_sh_vld <= w_xfer || (r_sh_vld && !w_take);
         if (w_xfer) begin
            r_sh_int <= (bus.i_cfg_int < INT_W'(MIN_INT)) ? INT_W'(MIN_INT) : bus.i_cfg_int;
            r_sh_frac <= bus.i_cfg_frac;
         end
         if (w_take) begin
            r_act_int <= r_sh_int;
            r_act_frac <= r_sh_frac;
         end
         if (w_load || w_edge_cyc) r_wait <= w_int_nx + INT_W'(w_edge_cyc && w_carry) - INT_W'(1);
         else if (r_state == RUN) r_wait <= r_wait - INT_W'(1);
         r_edge <= w_edge_cyc;
         if (w_edge_cyc) begin
            r_phidx <= r_pos;
            r_phsel <= 8'd1 << r_pos;
            r_dtc <= w_code;
         end
      end
   mpdiv_sched_acc #(.FRAC_W(FRAC_W), .DTC_W(DTC_W)) u_acc (
      .CLK(CLK),
      .NARST(NARST),
      .i_step(w_edge_cyc),
      .i_clr(w_load),
      .i_frac(r_act_frac),
      .o_carry(w_carry),
      .o_code(w_code)
   );
   assign bus.o_cfg_rdy = !r_sh_vld;
   assign bus.o_edge = r_edge;
   assign bus.o_phidx = r_phidx;
   assign bus.o_phsel = r_phsel;
   assign bus.o_dtc_code = r_dtc;
   assign bus.o_busy = w_busy;
endmodule
